// File: rtl/rnbip_fetch_decode.sv
// rnbip_fetch_decode: instruction fetch/decode sequencer driving the RNBIP-2 register file and ALU select.
// Build macro ILLEGAL_TRAP_EN: illegal opcodes halt the core with a sticky illegal flag.
module rnbip_fetch_decode #(
  parameter int unsigned         PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] pm_addr,
  input  logic [7:0]          pm_data,
  output logic [7:0]          or2,
  output logic [1:0]          enab,
  output logic [2:0]          mux_sel,
  output logic [2:0]          reg_sel,
  output logic [2:0]          seg,
  output logic [2:0]          alu_op,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPFETCH, S_OPLATCH, S_EXEC, S_EXEC_RD, S_EXEC_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_CLR, OP_HLT, OP_MOVN, OP_MOV0, OP_MVI, OP_ALU, OP_ILL
  } opc_t;

  localparam logic [1:0] EN_CLR  = 2'b00;
  localparam logic [1:0] EN_WR   = 2'b01;
  localparam logic [1:0] EN_IDLE = 2'b10;
  localparam logic [1:0] EN_RD   = 2'b11;

  function automatic opc_t classify(input logic [7:0] op);
    if (op == 8'h00)             return OP_NOP;
    else if (op == 8'h01)        return OP_CLR;
    else if (op == 8'h0F)        return OP_HLT;
    else if (op[7:3] == 5'b00010) return OP_MOVN;
    else if (op[7:3] == 5'b00011) return OP_MOV0;
    else if (op[7:3] == 5'b00100) return OP_MVI;
    else if (op[7:6] == 2'b01)   return OP_ALU;
    else                          return OP_ILL;
  endfunction

  state_t               state, next;
  logic [PC_WIDTH-1:0]  pc;
  logic [7:0]           ir;
  opc_t                 ir_class, pm_class;

  assign pm_addr  = pc;
  assign ir_class = classify(ir);
  assign pm_class = classify(pm_data);
  assign halted   = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= PC_RESET;
      ir  <= '0;
      or2 <= '0;
    end else begin
      if (state == S_DECODE) begin
        ir <= pm_data;
        pc <= pc + PC_WIDTH'(1);
      end
      if (state == S_OPLATCH) begin
        or2 <= pm_data;
        pc  <= pc + PC_WIDTH'(1);
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (reset)                                          illegal_q <= 1'b0;
    else if (state == S_DECODE && pm_class == OP_ILL) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = (state == S_EXEC) && (ir_class == OP_ILL) && !reset;
`endif

  always_comb begin
    next    = state;
    enab    = EN_IDLE;
    mux_sel = '0;
    reg_sel = '0;
    seg     = '0;
    alu_op  = '0;
    case (state)
      S_FETCH:  next = S_DECODE;
      S_DECODE: begin
        case (pm_class)
          OP_MVI:  next = S_OPFETCH;
          OP_ALU:  next = S_EXEC_RD;
          OP_HLT:  next = S_HALT;
`ifdef ILLEGAL_TRAP_EN
          OP_ILL:  next = S_HALT;
`endif
          default: next = S_EXEC;
        endcase
      end
      S_OPFETCH: next = S_OPLATCH;
      S_OPLATCH: next = S_EXEC;
      S_EXEC: begin
        next = S_FETCH;
        case (ir_class)
          OP_CLR:  enab = EN_CLR;
          OP_MOVN: begin enab = EN_WR; mux_sel = 3'b000; seg = ir[2:0]; end
          OP_MOV0: begin enab = EN_WR; mux_sel = 3'b001; reg_sel = ir[2:0]; end
          OP_MVI:  begin enab = EN_WR; mux_sel = 3'b010; seg = ir[2:0]; end
          default: enab = EN_IDLE;
        endcase
      end
      S_EXEC_RD: begin
        next   = S_EXEC_WB;
        enab   = EN_RD;
        seg    = ir[2:0];
        alu_op = ir[5:3];
      end
      S_EXEC_WB: begin
        next    = S_FETCH;
        enab    = EN_WR;
        mux_sel = 3'b011;
        alu_op  = ir[5:3];
      end
      S_HALT:  next = S_HALT;
      default: next = S_FETCH;
    endcase
    // Reset overrides the decoded controls so an abandoned instruction never writes.
    if (reset) begin
      enab    = EN_IDLE;
      mux_sel = '0;
      reg_sel = '0;
      seg     = '0;
      alu_op  = '0;
    end
  end

endmodule
